// File: rtl/aes_pkg.sv
// aes_pkg: shared AES datapath sizes, block type and output-buffer FSM states
package aes_pkg;
    localparam int N = 16;
    localparam int N_ROUNDS = 14;
    localparam int W = 32;
    typedef logic [N-1:0][7:0] block_t;
    typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/aes_ct_out_buffer_if.sv
// aes_ct_out_buffer_if: ciphertext capture and word-stream signals between datapath, buffer and sink
interface aes_ct_out_buffer_if;
    import aes_pkg::*;
    block_t       ct_in;
    logic         ct_vld;
    logic [W-1:0] out_word;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         ovf;
    modport master (output ct_in, ct_vld, out_ready, input out_word, out_valid, out_last, ovf);
    modport slave  (input ct_in, ct_vld, out_ready, output out_word, out_valid, out_last, ovf);
endinterface

// File: rtl/aes_word_pack.sv
// aes_word_pack: selects word idx of a block; big-endian bytes unless AES_CT_OUT_LE_EN is defined
module aes_word_pack
    import aes_pkg::*;
(
    input  block_t       blk,
    input  logic [1:0]   idx,
    output logic [W-1:0] word
);
    always_comb begin
        word = '0;
        for (int j = 0; j < 4; j++)
`ifdef AES_CT_OUT_LE_EN
            word[8*j +: 8] = blk[{idx, 2'(j)}];
`else
            word[8*(3-j) +: 8] = blk[{idx, 2'(j)}];
`endif
    end
endmodule

// File: rtl/aes_ct_out_buffer.sv
// aes_ct_out_buffer: two-slot ciphertext buffer streaming 4 words per block; packing set by AES_CT_OUT_LE_EN
module aes_ct_out_buffer
    import aes_pkg::*;
(
    input logic               clk,
    input logic               rstn,
    aes_ct_out_buffer_if.slave bus
);
    state_t       state_q, state_d;
    block_t       slot_q [2];
    block_t       slot_d [2];
    logic         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ovf_q, ovf_d;
    logic [1:0]   count_q, count_d, widx_q, widx_d;
    logic         out_valid, xfer, last_xfer, accept;
    logic [W-1:0] word;

    assign out_valid = state_q == SEND;

    always_comb begin
        xfer      = out_valid && bus.out_ready;
        last_xfer = xfer && widx_q == 2'd3;
        // a full buffer can still take a block in the cycle its oldest slot drains
        accept    = bus.ct_vld && (count_q < 2'd2 || (count_q == 2'd2 && last_xfer));
        slot_d    = slot_q;
        if (accept) slot_d[wr_ptr_q] = bus.ct_in;
        wr_ptr_d  = wr_ptr_q ^ accept;
        rd_ptr_d  = rd_ptr_q ^ last_xfer;
        widx_d    = widx_q + 2'(xfer);
        count_d   = count_q + 2'(accept) - 2'(last_xfer);
        ovf_d     = ovf_q || (bus.ct_vld && !accept);
        state_d   = count_d != 2'd0 ? SEND : IDLE;
    end

    always_ff @(posedge clk) begin
        slot_q <= slot_d;
        if (!rstn) begin
            state_q  <= IDLE;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ovf_q    <= 1'b0;
            count_q  <= 2'd0;
            widx_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            widx_q   <= widx_d;
        end
    end

    aes_word_pack u_pack (
        .blk  (slot_q[rd_ptr_q]),
        .idx  (widx_q),
        .word (word)
    );

    assign bus.out_valid = out_valid;
    assign bus.out_word  = out_valid ? word : '0;
    assign bus.out_last  = out_valid && widx_q == 2'd3;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_aes_ct_out_buffer.sv
// tb_aes_ct_out_buffer: directed and random stimulus checked against a block-queue reference model
module tb_aes_ct_out_buffer;
    import aes_pkg::*;

    logic clk;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    aes_ct_out_buffer_if bus();

    aes_ct_out_buffer dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    block_t q_m[$];
    int     widx_m = 0;
    bit     ovf_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_ref(input block_t b, input int i);
`ifdef AES_CT_OUT_LE_EN
        return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
`else
        return {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
`endif
    endfunction

    function automatic block_t rand_blk();
        block_t b;
        for (int i = 0; i < N; i++) b[i] = 8'($urandom);
        return b;
    endfunction

    task automatic model_update(input bit rn, input bit vld, input block_t blk, input bit rdy);
        bit pop;
        if (!rn) begin
            q_m.delete();
            widx_m = 0;
            ovf_m  = 0;
            return;
        end
        pop = q_m.size() > 0 && rdy && widx_m == 3;
        if (q_m.size() > 0 && rdy) widx_m = (widx_m + 1) % 4;
        if (pop) void'(q_m.pop_front());
        if (vld) begin
            if (q_m.size() < 2) q_m.push_back(blk);
            else ovf_m = 1;
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = q_m.size() > 0;
        chk("out_valid", 32'(bus.out_valid), 32'(v));
        chk("out_word", bus.out_word, v ? pack_ref(q_m[0], widx_m) : 32'h0);
        chk("out_last", 32'(bus.out_last), 32'(v && widx_m == 3));
        chk("ovf", 32'(bus.ovf), 32'(ovf_m));
    endtask

    task automatic cycle(input bit rn, input bit vld, input block_t blk, input bit rdy);
        rstn          = rn;
        bus.ct_vld    = vld;
        bus.ct_in     = blk;
        bus.out_ready = rdy;
        @(posedge clk);
        model_update(rn, vld, blk, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    block_t seq_blk, a, b, c, d;
    bit     rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        for (int i = 0; i < N; i++) seq_blk[i] = 8'(i);
        a = rand_blk();
        b = rand_blk();
        c = rand_blk();
        d = rand_blk();

        // reset, with a ct_vld that must be ignored
        cycle(0, 0, '0, 1);
        cycle(0, 1, a, 1);
        cycle(0, 0, '0, 1);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_word", bus.out_word, 32'd0);
        chk("reset_ovf", 32'(bus.ovf), 32'd0);

        // single block, known bytes
        cycle(1, 1, seq_blk, 1);
`ifdef AES_CT_OUT_LE_EN
        chk("single_w0", bus.out_word, 32'h03020100);
`else
        chk("single_w0", bus.out_word, 32'h00010203);
`endif
        for (int i = 0; i < 4; i++) cycle(1, 0, '0, 1);
        chk("single_idle", 32'(bus.out_valid), 32'd0);

        // backpressure pattern over two blocks
        cycle(1, 1, a, 0);
        cycle(1, 1, b, 0);
        for (int i = 0; i < 20; i++) cycle(1, 0, '0, rdy_pat[i % 4]);

        // fill and drop
        cycle(1, 1, a, 0);
        cycle(1, 1, b, 0);
        cycle(1, 1, c, 0);
        chk("drop_ovf", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < 9; i++) cycle(1, 0, '0, 1);

        // simultaneous free and accept while full
        cycle(0, 0, '0, 0);
        cycle(1, 1, a, 0);
        cycle(1, 1, b, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, 1);
        cycle(1, 1, d, 1);
        chk("simul_ovf", 32'(bus.ovf), 32'd0);
        for (int i = 0; i < 8; i++) cycle(1, 0, '0, 1);

        // reset mid-stream, then a fresh block
        cycle(1, 1, c, 1);
        cycle(1, 0, '0, 1);
        cycle(0, 0, '0, 1);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        cycle(1, 1, seq_blk, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, '0, 1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(99) != 0, $urandom_range(99) < 35, rand_blk(), $urandom_range(99) < 70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
